// File: rtl/alu_exec_pkg.sv
// Shared types and sizing for the ALU operation executor.
package alu_exec_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH;
    localparam int MUL_STEPS    = DATA_WIDTH;
    localparam int CNT_WIDTH    = $clog2(MUL_STEPS);

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } alu_state_t;

endpackage

// File: rtl/alu_op_executor_if.sv
// ALU_in / ALU_out handshake bundle between initiator and executor.
interface alu_op_executor_if;
    import alu_exec_pkg::*;

    logic                    valid;
    logic [2:0]              op;
    logic [DATA_WIDTH-1:0]   a;
    logic [DATA_WIDTH-1:0]   b;
    logic                    ready;
    logic                    done;
    logic [RESULT_WIDTH-1:0] result;

    modport master (
        output valid, op, a, b,
        input  ready, done, result
    );

    modport slave (
        input  valid, op, a, b,
        output ready, done, result
    );

endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
module alu_shift_add_mul
    import alu_exec_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic                    busy_o,
    output logic                    last_o,
    output logic [RESULT_WIDTH-1:0] product_o
);

    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [RESULT_WIDTH-1:0] mcnd_q;
    logic [RESULT_WIDTH-1:0] acc_q;
    logic [RESULT_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0]   mplr_q;
    logic                    busy_q;

    // product_o already folds in the current step, so it is final on last_o
    assign acc_d     = acc_q + (mplr_q[0] ? mcnd_q : '0);
    assign busy_o    = busy_q;
    assign last_o    = busy_q && (cnt_q == CNT_WIDTH'(MUL_STEPS - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            mcnd_q <= '0;
            mplr_q <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            mcnd_q <= {{DATA_WIDTH{1'b0}}, a_i};
            mplr_q <= b_i;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q  <= acc_d;
            mcnd_q <= mcnd_q << 1;
            mplr_q <= mplr_q >> 1;
            cnt_q  <= cnt_q + 1'b1;
            if (last_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_op_executor.sv
// Executor endpoint: accepts ops over the valid/ready bus, returns a done pulse.
module alu_op_executor
    import alu_exec_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_op_executor_if.slave   bus
);

    alu_state_t              state_q;
    alu_state_t              state_d;
    alu_op_t                 op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [RESULT_WIDTH-1:0] result_q;
    logic [RESULT_WIDTH-1:0] result_d;
    logic [RESULT_WIDTH-1:0] alu_res;
    logic [RESULT_WIDTH-1:0] mul_prod;
    logic                    mul_busy;
    logic                    mul_last;
    logic                    ready;
    logic                    done;
    logic                    accept;
    logic                    is_alu;
    logic                    is_mul;
    logic                    is_clr;

    assign accept = bus.valid && ready;

    always_comb begin
        is_alu = 1'b0;
        is_mul = 1'b0;
        is_clr = 1'b0;
        if (accept) begin
            unique case (1'b1)
                bus.op == add_op,
                bus.op == and_op,
                bus.op == xor_op: is_alu = 1'b1;
                bus.op == mul_op: is_mul = 1'b1;
                bus.op == rst_op: is_clr = 1'b1;
                default: ;
            endcase
        end
    end

    alu_shift_add_mul u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_mul),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .busy_o    (mul_busy),
        .last_o    (mul_last),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (is_alu) begin
                    state_d = EXEC;
                end else if (is_mul) begin
                    state_d = MUL;
                end
            end
            EXEC: state_d = DONE;
            MUL: begin
                if (mul_busy && mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        unique case (1'b1)
            state_q == IDLE: ready = 1'b1;
            state_q == DONE: done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= no_op;
            a_q  <= '0;
            b_q  <= '0;
        end else if (is_alu) begin
            op_q <= alu_op_t'(bus.op);
            a_q  <= bus.a;
            b_q  <= bus.b;
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (op_q)
            add_op:  alu_res = {{DATA_WIDTH{1'b0}}, a_q}
                             + {{DATA_WIDTH{1'b0}}, b_q};
            and_op:  alu_res = {{DATA_WIDTH{1'b0}}, a_q & b_q};
            xor_op:  alu_res = {{DATA_WIDTH{1'b0}}, a_q ^ b_q};
            default: alu_res = '0;
        endcase
    end

    // result only moves on DONE entry or an accepted rst_op
    always_comb begin
        result_d = result_q;
        if (is_clr) begin
            result_d = '0;
        end else if (state_q == EXEC) begin
            result_d = alu_res;
        end else if (state_q == MUL && mul_busy && mul_last) begin
            result_d = mul_prod;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.ready  = ready;
    assign bus.done   = done;
    assign bus.result = result_q;

endmodule

// File: tb/tb_alu_op_executor.sv
// Directed bench for alu_op_executor: latency, results, handshake and reset.
module tb_alu_op_executor;
    import alu_exec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    alu_op_executor_if bus ();

    alu_op_executor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        bus.valid = v;
        bus.op    = o;
        bus.a     = a;
        bus.b     = b;
    endtask

    // accept one op, then walk cycle by cycle to the done pulse
    task automatic run_op(input string tag, input logic [2:0] o,
                          input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [15:0] exp);
        chk({tag, "_ready_pre"}, 32'(bus.ready), 32'd1);
        drive(1'b1, o, a, b);
        tick;
        drive(1'b0, o, ~a, ~b);
        for (int i = 1; i <= lat; i++) begin
            chk($sformatf("%s_ready_c%0d", tag, i), 32'(bus.ready), 32'd0);
            chk($sformatf("%s_done_c%0d", tag, i), 32'(bus.done),
                (i == lat) ? 32'd1 : 32'd0);
            if (i == lat) begin
                chk({tag, "_result"}, 32'(bus.result), 32'(exp));
            end else begin
                tick;
            end
        end
        tick;
        chk({tag, "_ready_post"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done_post"}, 32'(bus.done), 32'd0);
        chk({tag, "_result_held"}, 32'(bus.result), 32'(exp));
    endtask

    initial begin
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        rst = 1'b1;
        tick;
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        chk("post_rst_done", 32'(bus.done), 32'd0);

        run_op("add_ff_01", 3'd1, 8'hFF, 8'h01, 2, 16'h0100);
        run_op("mul_ff_ff", 3'd4, 8'hFF, 8'hFF, 9, 16'hFE01);
        run_op("xor_a5_5a", 3'd3, 8'hA5, 8'h5A, 2, 16'h00FF);
        run_op("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 2, 16'h0030);
        run_op("mul_0d_0b", 3'd4, 8'h0D, 8'h0B, 9, 16'h008F);
        run_op("mul_00_c3", 3'd4, 8'h00, 8'hC3, 9, 16'h0000);
        run_op("mul_80_02", 3'd4, 8'h80, 8'h02, 9, 16'h0100);
        run_op("add_7f_80", 3'd1, 8'h7F, 8'h80, 2, 16'h00FF);

        // valid held high with operands changing every cycle
        drive(1'b1, 3'd1, 8'h10, 8'h20);
        tick;
        chk("hold_busy_ready", 32'(bus.ready), 32'd0);
        chk("hold_busy_done", 32'(bus.done), 32'd0);
        drive(1'b1, 3'd1, 8'h33, 8'h44);
        tick;
        chk("hold_done1", 32'(bus.done), 32'd1);
        chk("hold_result1", 32'(bus.result), 32'h0030);
        drive(1'b1, 3'd1, 8'h01, 8'h02);
        tick;
        chk("hold_idle_ready", 32'(bus.ready), 32'd1);
        chk("hold_idle_done", 32'(bus.done), 32'd0);
        drive(1'b1, 3'd1, 8'h05, 8'h06);
        tick;
        chk("hold_exec2_ready", 32'(bus.ready), 32'd0);
        chk("hold_exec2_done", 32'(bus.done), 32'd0);
        drive(1'b1, 3'd1, 8'h77, 8'h77);
        tick;
        chk("hold_done2", 32'(bus.done), 32'd1);
        chk("hold_result2", 32'(bus.result), 32'h000B);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick;
        chk("hold_end_done", 32'(bus.done), 32'd0);
        chk("hold_end_ready", 32'(bus.ready), 32'd1);

        // rst_op clears result, undefined ops do nothing
        run_op("add_pre_clr", 3'd1, 8'hFF, 8'h01, 2, 16'h0100);
        drive(1'b1, 3'd7, 8'hAA, 8'h55);
        tick;
        chk("clr_result", 32'(bus.result), 32'd0);
        chk("clr_ready", 32'(bus.ready), 32'd1);
        chk("clr_done", 32'(bus.done), 32'd0);
        drive(1'b1, 3'd5, 8'h12, 8'h34);
        tick;
        chk("op5_ready", 32'(bus.ready), 32'd1);
        chk("op5_done", 32'(bus.done), 32'd0);
        chk("op5_result", 32'(bus.result), 32'd0);
        drive(1'b1, 3'd6, 8'h12, 8'h34);
        tick;
        drive(1'b1, 3'd0, 8'h12, 8'h34);
        tick;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick;
        chk("op6_nop_ready", 32'(bus.ready), 32'd1);
        chk("op6_nop_done", 32'(bus.done), 32'd0);
        chk("op6_nop_result", 32'(bus.result), 32'd0);

        // reset during a multiply aborts it with no done
        run_op("add_12_34", 3'd1, 8'h12, 8'h34, 2, 16'h0046);
        drive(1'b1, 3'd4, 8'hFF, 8'hFF);
        tick;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        repeat (3) tick;
        chk("abort_busy_ready", 32'(bus.ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        tick;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            chk($sformatf("abort_nodone_c%0d", i), 32'(bus.done), 32'd0);
        end
        chk("abort_idle_result", 32'(bus.result), 32'd0);
        run_op("add_01_02", 3'd1, 8'h01, 8'h02, 2, 16'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
